ps2_rx: RTL and testbench
=========================

// Module: ps2_rx
// PURPOSE
//  Receives PS/2 device-to-host frames and emits one byte strobe per good frame.
//  Feeds the scancode consumers (shift tracking, make/break decoding) through o_byte / o_byte_en.
//  Synchronises and deglitches the raw PS/2 clock/data pins, samples on falling edges,
//  checks frame integrity and recovers from stalled frames.
// PARAMETERS
//  FILTER_LEN      8       sys-clk cycles the synced ps2 clock must hold a level before the filtered clock follows it
//  TIMEOUT_CYCLES  100000  max sys-clk cycles between falling edges inside a frame (2 ms @ 50 MHz)
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  i_rst_n       in   1  asynchronous, active-low reset
//  i_ps2_clk     in   1  raw PS/2 clock pin (asynchronous)
//  i_ps2_data    in   1  raw PS/2 data pin (asynchronous)
//  o_byte        out  8  last received data byte; held until the next good frame
//  o_byte_en     out  1  one-cycle strobe: o_byte is valid
//  o_parity_err  out  1  one-cycle strobe: frame dropped on odd-parity failure
//  o_frame_err   out  1  one-cycle strobe: frame dropped on bad stop bit or timeout
// BEHAVIOUR
//  - Reset: all outputs 0. State IDLE, shift register 0, bit count 0, timeout counter 0.
//    Filtered clock = 1. Sync flops = 1 (bus-idle level). Asserting reset mid-frame discards the frame.
//  - Input sync: both pins pass through 2 flops.
//  - Filter: the filtered clock takes the new level after FILTER_LEN consecutive equal synced samples.
//    Shorter pulses are ignored. Data uses the synced sample only (no filter).
//  - Edge: fall = filtered_q & ~filtered_d. Every sampling action below happens only on a fall cycle.
//  - Frame: 11 bits = start(0), d0..d7 (LSB first), odd parity, stop(1).
//  - FSM:
//    IDLE   : on fall with data 0, go to DATA with cnt = 0. Data 1 on a fall is a glitch: stay in IDLE, no error.
//    DATA   : on fall, shift the data in at MSB (right-shift). Increment cnt. When cnt wraps at 8, go to PARITY.
//    PARITY : on fall, capture the parity bit and go to STOP.
//    STOP   : on fall, evaluate the frame and go to IDLE:
//             stop = 0                  -> o_frame_err
//             stop = 1, ^{d,par} = 0    -> o_parity_err
//             otherwise                 -> o_byte <= d, o_byte_en
//  - Latency: the strobe is high in the cycle after the stop-bit fall, for exactly 1 cycle.
//    At most one of the three strobes fires per frame.
//  - Timeout: in any non-IDLE state the counter increments every cycle and clears on each fall.
//    On reaching TIMEOUT_CYCLES-1: o_frame_err strobe, go to IDLE, clear shift register and cnt.
//    If a fall and the terminal count land in the same cycle, the fall wins (no timeout).
//    Counter width = $clog2(TIMEOUT_CYCLES); it is held at 0 in IDLE.
//  - Back-to-back frames: a start bit on the first fall after STOP is accepted. No idle gap is required.
//  - Host-to-device transmission is out of scope. Both pins are input-only here.
// STRUCTURE
//  - Shared header ps2_defs.vh holds:
//    - PS2_FRAME_BITS = 11
//    - PS2_BREAK_CODE = 8'hF0
//    - PS2_EXT_CODE = 8'hE0
//    - the FSM state encodings (IDLE/DATA/PARITY/STOP, 2 bits)
//    Downstream decoders reuse the same break/extend constants.
//  - One sub-module, ps2_sync_filter: 2-flop synchroniser plus the FILTER_LEN stable-level filter.
//    Instantiated for the clock pin; outputs the filtered level and the fall pulse.
//  - The top level holds the FSM, 8-bit shift register, 3-bit bit counter, parity capture and timeout counter.
// TESTING
//  1 Reset: hold i_rst_n=0, toggle pins -> all outputs 0. Release, no pin activity -> no strobes for 10000 cycles.
//  2 Good frame 0x1C (parity 0) at 12.5 kHz -> o_byte=8'h1C, o_byte_en high exactly 1 cycle after the 11th fall.
//    Then send 0xF0 and 0x12 -> three strobes in order.
//  3 Frame 0x1C with parity 1 -> o_parity_err 1-cycle pulse, o_byte_en stays 0, o_byte keeps its prior value.
//    Stop bit 0 -> o_frame_err instead.
//  4 Send 5 bits then stall the clock high -> o_frame_err exactly TIMEOUT_CYCLES after the last fall.
//    The next full frame 0x59 is then received correctly.
//  5 Inject clock glitches of FILTER_LEN-1 cycles mid-bit during frame 0x12 -> byte 0x12 received, no errors.
//    A glitch of FILTER_LEN+2 cycles corrupts alignment and must end in an error strobe, not a hang.
//  6 Pulse i_rst_n low after bit 4 of a frame -> outputs 0 immediately.
//    The partial frame produces no strobe. The next frame 0xF0 is received.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// PS/2 receiver shared definitions.
// Frame constants, scancode constants and FSM state encoding.
package ps2_rx_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // Odd parity holds when data plus parity bit carry an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_sync_filter.sv
// PS/2 clock pin conditioning.
// Two-flop synchroniser, stable-level deglitch filter and falling-edge pulse.
module ps2_rx_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic fall
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic          filt;
    logic          filt_prev;
    logic [FW-1:0] cnt;

    // Synchronise, then let the filtered level follow only after a stable run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            cnt       <= '0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            filt_prev <= filt;
            if (sync2 != filt) begin
                if (cnt == FW'(FILTER_LEN - 1)) begin
                    filt <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + FW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign fall = filt_prev & ~filt;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver.
// Samples frames on filtered clock falls, checks framing/parity, times out stalls.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_en,
    output logic       o_parity_err,
    output logic       o_frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    ps2_state_t    state;
    logic [7:0]    shreg;
    logic [2:0]    cnt;
    logic          par;
    logic [TW-1:0] tmo;
    logic          fall;
    logic          data_s1;
    logic          data_s2;

    ps2_rx_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst_n(i_rst_n),
        .raw  (i_ps2_clk),
        .fall (fall)
    );

    // Data pin only needs synchronising; it is sampled well inside the bit.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            data_s1 <= i_ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Frame FSM with stall timeout; strobes are registered one-cycle pulses.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            cnt          <= '0;
            par          <= 1'b0;
            tmo          <= '0;
            o_byte       <= '0;
            o_byte_en    <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_en    <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            if (state == ST_IDLE) begin
                tmo <= '0;
                if (fall && !data_s2) begin
                    state <= ST_DATA;
                    cnt   <= '0;
                end
            end else if (fall) begin
                tmo <= '0;
                unique case (state)
                    ST_DATA: begin
                        shreg <= {data_s2, shreg[7:1]};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par   <= data_s2;
                        state <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (!data_s2) begin
                            o_frame_err <= 1'b1;
                        end else if (!odd_parity_ok(shreg, par)) begin
                            o_parity_err <= 1'b1;
                        end else begin
                            o_byte    <= shreg;
                            o_byte_en <= 1'b1;
                        end
                    end
                endcase
            end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                o_frame_err <= 1'b1;
                state       <= ST_IDLE;
                shreg       <= '0;
                cnt         <= '0;
                tmo         <= '0;
            end else begin
                tmo <= tmo + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed testbench for ps2_rx.
// Drives PS/2 frames with a slow bus clock and checks strobes, bytes and latency.
module tb_ps2_rx;

    localparam int F = 8;
    localparam int T = 2000;
    localparam int H = 150;
    localparam int LAT = F + 3;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       byte_en;
    logic       parity_err;
    logic       frame_err;

    int checks;
    int failures;
    int cyc;
    int fall_cyc;
    int en_cnt;
    int perr_cnt;
    int ferr_cnt;
    int en_cyc;
    int perr_cyc;
    int ferr_cyc;
    int e0;
    int p0;
    int f0;

    ps2_rx #(
        .FILTER_LEN    (F),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_data  (ps2_data),
        .o_byte      (rx_byte),
        .o_byte_en   (byte_en),
        .o_parity_err(parity_err),
        .o_frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (byte_en) begin
            en_cnt <= en_cnt + 1;
            en_cyc <= cyc;
        end
        if (parity_err) begin
            perr_cnt <= perr_cnt + 1;
            perr_cyc <= cyc;
        end
        if (frame_err) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus bit: data set while clock high, fall, rise, optional glitch after.
    task automatic ps2_bit(input logic b, input int glitch);
        ps2_data = b;
        wait_cyc(H);
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        wait_cyc(H);
        ps2_clk = 1'b1;
        if (glitch > 0) begin
            wait_cyc(50);
            ps2_clk = 1'b0;
            wait_cyc(glitch);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop, input int gbit, input int glen);
        logic [10:0] bits;
        bits = {stop, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_bit(bits[i], (i == gbit) ? glen : 0);
        end
        ps2_data = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic snap;
        e0 = en_cnt;
        p0 = perr_cnt;
        f0 = ferr_cnt;
    endtask

    task automatic good_frame(input string tag, input logic [7:0] d);
        snap();
        send_frame(d, 1'b0, 1'b1, -1, 0);
        check({tag, "_en_count"}, en_cnt - e0, 1);
        check({tag, "_byte"}, {24'd0, rx_byte}, {24'd0, d});
        check({tag, "_latency"}, en_cyc - fall_cyc, LAT);
        check({tag, "_no_err"}, (perr_cnt - p0) + (ferr_cnt - f0), 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        en_cnt = 0;
        perr_cnt = 0;
        ferr_cnt = 0;
        en_cyc = 0;
        perr_cyc = 0;
        ferr_cyc = 0;
        fall_cyc = 0;
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;

        // Reset held while pins toggle.
        for (int i = 0; i < 20; i++) begin
            wait_cyc(13);
            ps2_clk = ~ps2_clk;
            ps2_data = (i % 3) == 0;
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        check("rst_outputs", {21'd0, rx_byte, byte_en, parity_err, frame_err}, 0);
        check("rst_no_strobes", en_cnt + perr_cnt + ferr_cnt, 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(10000);
        check("idle_no_strobes", en_cnt + perr_cnt + ferr_cnt, 0);

        // Good frames in order.
        good_frame("f1C", 8'h1C);
        good_frame("fF0", 8'hF0);
        good_frame("f12", 8'h12);

        // Bad parity, then bad stop bit.
        snap();
        send_frame(8'h1C, 1'b1, 1'b1, -1, 0);
        check("par_perr", perr_cnt - p0, 1);
        check("par_perr_lat", perr_cyc - fall_cyc, LAT);
        check("par_no_en", en_cnt - e0, 0);
        check("par_byte_hold", {24'd0, rx_byte}, 32'h12);
        snap();
        send_frame(8'h1C, 1'b0, 1'b0, -1, 0);
        check("stop_ferr", ferr_cnt - f0, 1);
        check("stop_no_other", (en_cnt - e0) + (perr_cnt - p0), 0);

        // Stall after five bits.
        snap();
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_data = 1'b1;
        wait_cyc(T + 200);
        check("tmo_ferr", ferr_cnt - f0, 1);
        check("tmo_lat", ferr_cyc - fall_cyc, LAT + T);
        check("tmo_no_other", (en_cnt - e0) + (perr_cnt - p0), 0);
        good_frame("f59", 8'h59);

        // Short glitches are filtered out.
        snap();
        send_frame(8'h12, 1'b0, 1'b1, 3, F - 1);
        check("gl_short_en", en_cnt - e0, 1);
        check("gl_short_byte", {24'd0, rx_byte}, 32'h12);
        check("gl_short_err", (perr_cnt - p0) + (ferr_cnt - f0), 0);
        snap();
        send_frame(8'h12, 1'b0, 1'b1, 5, F - 1);
        check("gl_short2_en", en_cnt - e0, 1);

        // A long glitch adds a fall; the frame must end in an error.
        snap();
        send_frame(8'h12, 1'b0, 1'b1, 0, F + 2);
        check("gl_long_err", (perr_cnt - p0) + (ferr_cnt - f0) > 0, 1);
        check("gl_long_no_en", en_cnt - e0, 0);
        wait_cyc(T + 200);
        good_frame("f2A", 8'h2A);

        // Reset mid-frame.
        snap();
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_data = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {21'd0, rx_byte, byte_en, parity_err, frame_err}, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(T + 200);
        check("mid_rst_no_strobe", (en_cnt - e0) + (perr_cnt - p0) + (ferr_cnt - f0), 0);
        good_frame("rF0", 8'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
